// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: word width, opcode constants and
// the prefetch queue entry layout used by the fetch front end.
package mips32_pkg;

    localparam int WORD_W = 32;

    // Opcode field is ir[31:26]
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // One prefetch queue entry: instruction word and the address after it
    typedef struct packed {
        logic [WORD_W-1:0] ir;
        logic [WORD_W-1:0] npc;
    } fq_entry_t;

    function automatic logic is_hlt(input logic [WORD_W-1:0] ir);
        return ir[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Parameterised synchronous FIFO with flush, occupancy count and
// full/empty flags. Push while full is accepted only with a same-cycle pop.
// The head output reads zero while the FIFO is empty.
module mips32_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Entry storage; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the FIFO like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction fetch front end: issues word-address requests to
// instruction memory, queues returned words with their next-PC, and feeds
// the ID stage. Taken-branch redirects flush the queue and drop in-flight
// responses; fetching stops once an HLT word has been queued.
// Optional macro FETCH_QUEUE_PERF_CNT_EN adds saturating performance counters.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [WORD_W-1:0] id_ir,
    output logic [WORD_W-1:0] id_npc,
    output logic              fetch_stopped
`ifdef FETCH_QUEUE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped,
    output logic [31:0]       perf_stall
`endif
);

    // Handshakes: a transfer happens on a clock edge where valid && ready are
    // both high; valid never waits on ready. Memory responses carry no ready
    // and arrive in request order; the request credit check guarantees a
    // kept response always finds queue space.

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] rsp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;
    logic [CW:0]       credit;
    logic              req_fire;
    logic              rsp_fire;
    logic              rsp_keep;
    logic              q_push;
    logic              q_pop;
    fq_entry_t         q_in;
    fq_entry_t         q_head;

    // Words already queued plus kept responses still in flight
    assign credit = {1'b0, q_count} + {1'b0, outstanding} - {1'b0, drop_cnt};

    assign imem_req_valid = !rst && !fetch_stopped && !redirect_valid
                            && (outstanding < CW'(MAX_OUT))
                            && (credit < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are stale (issued before reset)
    assign rsp_fire = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep = rsp_fire && (drop_cnt == '0);

    assign q_in.ir  = imem_rsp_data;
    assign q_in.npc = rsp_pc + 32'd1;
    assign q_push   = rsp_keep && !redirect_valid && (!q_full || q_pop);
    assign q_pop    = id_valid && id_ready && !redirect_valid;

    assign id_valid = !q_empty;
    assign id_ir    = q_head.ir;
    assign id_npc   = q_head.npc;

    mips32_sync_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Request PC: redirect wins, otherwise advance on each accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (req_fire) begin
            pc <= pc + 32'd1;
        end
    end

    // Address of the next kept response, used to build each entry's next-PC
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            rsp_pc <= redirect_pc;
        end else if (rsp_keep) begin
            rsp_pc <= rsp_pc + 32'd1;
        end
    end

    // In-flight request count and the number of responses still to discard
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (redirect_valid) begin
                drop_cnt <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            end else if (rsp_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // Stop requesting once an HLT word enters the queue; a redirect restarts
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            fetch_stopped <= 1'b0;
        end else if (q_push && is_hlt(imem_rsp_data)) begin
            fetch_stopped <= 1'b1;
        end
    end

`ifdef FETCH_QUEUE_PERF_CNT_EN
    // Saturating counters for kept responses, dropped responses and ID starvation
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (rsp_keep && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (rsp_fire && (drop_cnt != '0) && (perf_dropped != '1)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if (id_ready && !id_valid && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: an in-order memory model with
// configurable latency, a reference PC-sequence scoreboard for the ID stream,
// and directed phases for back-pressure, redirect, halt and mid-burst reset,
// followed by a long randomised run.
module tb_mips32_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_npc;
    logic        fetch_stopped;
`ifdef FETCH_QUEUE_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    mips32_fetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_npc         (id_npc),
        .fetch_stopped  (fetch_stopped)
`ifdef FETCH_QUEUE_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_stall     (perf_stall)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bench state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          p_req    = 100;
    int          p_rsp    = 100;
    int          p_id     = 100;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          rst_drv  = 1'b1;
    bit          do_redir = 1'b0;
    logic [31:0] redir_target = '0;

    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc = RESET_PC;
    int          b_out = 0;

    bit          hlt_en   = 1'b0;
    logic [31:0] hlt_addr = '0;
    logic [31:0] max_acc  = '0;
    int          first_acc = -1;
    int          first_idv = -1;
    int          n_popped  = 0;
    bit          want_first = 1'b0;
    logic [31:0] first_ir  = '0;
    logic [31:0] first_npc = '0;

`ifdef FETCH_QUEUE_PERF_CNT_EN
    int          m_drop    = 0;
    logic [31:0] m_fetched = '0;
    logic [31:0] m_dropped = '0;
    logic [31:0] m_stall   = '0;
    bit          perf_chk  = 1'b0;
    logic [31:0] drop_snap = '0;
`endif

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents: a hashed word per address, never HLT unless placed
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        if (w[31:26] == 6'h3f) begin
            w[31:26] = 6'h3e;
        end
        if (hlt_en && (a == hlt_addr)) begin
            w = {6'h3f, a[25:0]};
        end
        return w;
    endfunction

    // ---------------- scoreboard / models ----------------
    task automatic observe();
        logic        acc;
        logic        rsp_f;
        logic [63:0] e;
        int          due;
        acc   = imem_req_valid && imem_req_ready;
        rsp_f = imem_rsp_valid && (b_out > 0);

`ifdef FETCH_QUEUE_PERF_CNT_EN
        if (perf_chk && !rst) begin
            check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
            check("perf_dropped", 64'(perf_dropped), 64'(m_dropped));
            check("perf_stall",   64'(perf_stall),   64'(m_stall));
            perf_chk = 1'b0;
        end
        if (rst) begin
            m_drop = 0; m_fetched = '0; m_dropped = '0; m_stall = '0;
        end else begin
            if (id_ready && !id_valid) m_stall++;
            if (rsp_f) begin
                if (m_drop > 0) begin
                    m_dropped++;
                    m_drop--;
                end else begin
                    m_fetched++;
                end
            end
        end
`endif

        // memory side: remember accepted addresses, in-order due times
        if (acc) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (mem_due_q.size() > 0 && due < mem_due_q[$]) due = mem_due_q[$];
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(due);
        end

        if (rst) begin
            b_out = 0;
            exp_q.delete();
            exp_pc    = RESET_PC;
            max_acc   = '0;
            first_acc = -1;
            first_idv = -1;
        end else begin
            b_out = b_out + int'(acc) - int'(rsp_f);
            if (redirect_valid) begin
                check("redir_no_req", 64'(imem_req_valid), 64'(0));
                exp_q.delete();
                exp_pc     = redirect_pc;
                want_first = 1'b1;
`ifdef FETCH_QUEUE_PERF_CNT_EN
                m_drop = b_out;
`endif
            end else begin
                if (id_valid && first_idv < 0) first_idv = cyc;
                if (id_valid && id_ready) begin
                    if (exp_q.size() == 0) begin
                        check("id_unexpected", 64'(id_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("id_word", {id_ir, id_npc}, e);
                        n_popped++;
                        if (want_first) begin
                            first_ir   = id_ir;
                            first_npc  = id_npc;
                            want_first = 1'b0;
                        end
                    end
                end
                if (acc) begin
                    check("req_addr", 64'(imem_req_addr), 64'(exp_pc));
                    exp_q.push_back({mem_word(exp_pc), exp_pc + 32'd1});
                    exp_pc  = exp_pc + 32'd1;
                    max_acc = imem_req_addr;
                    if (first_acc < 0) first_acc = cyc;
                end
            end
            if (!id_valid) check("idle_zero", {id_ir, id_npc}, 64'(0));
            check("credit", 64'(exp_q.size() <= DEPTH), 64'(1));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        cyc++;
        rst            = rst_drv;
        redirect_valid = do_redir;
        redirect_pc    = redir_target;
        do_redir       = 1'b0;
        imem_req_ready = ($urandom_range(0, 99) < p_req);
        id_ready       = ($urandom_range(0, 99) < p_id);
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc && $urandom_range(0, 99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        #1;
        observe();
    endtask

    // Reset with requests held off until every stale response has come back
    task automatic reset_and_drain();
        int saved;
        saved   = p_req;
        p_req   = 0;
        rst_drv = 1'b1;
        step();
        check("rst_req_valid", 64'(imem_req_valid), 64'(0));
        step();
        rst_drv = 1'b0;
        step();
        check("rst_id_valid", 64'(id_valid), 64'(0));
        check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        for (int i = 0; i < 60 && mem_due_q.size() > 0; i++) begin
            step();
            check("stale_ignored", {31'd0, id_valid, imem_req_addr}, {32'd0, RESET_PC});
        end
        check("stale_drained", 64'(mem_due_q.size()), 64'(0));
        p_req = saved;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = 1'b0;

        // reset state
        rst_drv = 1'b1;
        repeat (3) step();
        check("reset_req_valid", 64'(imem_req_valid), 64'(0));
        check("reset_id_valid",  64'(id_valid), 64'(0));
        check("reset_id_word",   {id_ir, id_npc}, 64'(0));
        check("reset_stopped",   64'(fetch_stopped), 64'(0));

        // streaming at latency 1
        rst_drv = 1'b0;
        repeat (40) step();
        check("first_latency", 64'(first_idv - first_acc), 64'(2));
        check("stream_rate", 64'(n_popped >= 30), 64'(1));

        // back-pressure: queue fills to DEPTH and requests stop
        p_id = 0;
        repeat (10) step();
        check("bp_queued", 64'(exp_q.size()), 64'(DEPTH));
        check("bp_id_valid", 64'(id_valid), 64'(1));
        check("bp_no_req", 64'(imem_req_valid), 64'(0));
        p_id = 100;
        repeat (20) step();

        // redirect with two requests in flight at latency 3
        lat_min = 3; lat_max = 3;
        repeat (12) step();
        for (int i = 0; i < 20 && b_out != 2; i++) step();
`ifdef FETCH_QUEUE_PERF_CNT_EN
        drop_snap = m_dropped;
`endif
        p_rsp = 0; do_redir = 1'b1; redir_target = 32'h40;
        step();
        p_rsp = 100;
        repeat (20) step();
        check("redir_first", {first_ir, first_npc}, {mem_word(32'h40), 32'h41});
`ifdef FETCH_QUEUE_PERF_CNT_EN
        check("perf_redir_drop", 64'(perf_dropped), 64'(drop_snap + 32'd2));
        perf_chk = 1'b1;
        step();
`endif

        // halt at address 5, then redirect restarts fetching
        lat_min = 1; lat_max = 1;
        hlt_en = 1'b1; hlt_addr = 32'd5;
        reset_and_drain();
        repeat (30) step();
        check("hlt_stopped", 64'(fetch_stopped), 64'(1));
        check("hlt_last_addr", 64'(max_acc), 64'(6));
        check("hlt_no_req", 64'(imem_req_valid), 64'(0));
        do_redir = 1'b1; redir_target = 32'h10;
        step();
        step();
        check("hlt_cleared", 64'(fetch_stopped), 64'(0));
        check("hlt_resume", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h10});
        repeat (20) step();
        hlt_en = 1'b0;

        // reset mid-burst with responses pending
        lat_min = 2; lat_max = 4;
        repeat (15) step();
        reset_and_drain();

        // randomised traffic with redirects
        p_req = 70; p_rsp = 70; p_id = 70;
        lat_min = 1; lat_max = 5;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_redir     = 1'b1;
                redir_target = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFE
                                                            : 32'($urandom_range(0, 1023));
            end
            step();
        end

        // stop requesting and let everything expected come out
        p_req = 0; p_rsp = 100; p_id = 100;
        repeat (60) step();
        check("final_drain", 64'(exp_q.size()), 64'(0));
`ifdef FETCH_QUEUE_PERF_CNT_EN
        perf_chk = 1'b1;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
